mem_responder: RTL and testbench

//   Word-addressed RAM responder for the valid/ready memory bus driven by the belt CPU.

---
 rtl/mem_responder.sv | 87 ++++++++
 tb/tb_mem_responder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: word-addressed SRAM responder with wait states; MEM_RESPONDER_OOR_EN enables error responses outside the window
module mem_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic [31:0] mem_rdata,
   output logic        mem_err
);
   localparam int         AW       = $clog2(DEPTH_WORDS);
   localparam logic [32:0] WIN     = 33'(DEPTH_WORDS) << 2;
   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;
   logic [1:0]    state;
   logic [31:0]   ram [DEPTH_WORDS];
   logic [31:0]   off, wdata_q;
   logic [3:0]    wstrb_q, cnt;
   logic [AW-1:0] idx_q, rd_idx;
   logic          hit, to_resp, rd_load;
   assign off       = mem_addr - BASE_ADDR;
   assign hit       = {1'b0, off} < WIN;
   assign mem_ready = state == ST_RESP;
`ifdef MEM_RESPONDER_OOR_EN
   logic err_q;
   assign mem_err = mem_ready && err_q;
`else
   assign mem_err = 1'b0;
`endif
   // Decide whether a read enters RESP this cycle and which word it fetches
   always_comb begin
      to_resp = state == ST_IDLE ? mem_valid && hit && WAIT_CYCLES == 0 :
                state == ST_WAIT ? mem_valid && cnt == 4'd0 : 1'b0;
      rd_idx  = state == ST_IDLE ? off[AW+1:2] : idx_q;
      rd_load = to_resp && (state == ST_IDLE ? mem_wstrb : wstrb_q) == 4'b0000;
   end
   // Request FSM: accept, count wait states, respond, and capture read data on entry to RESP
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         cnt       <= 4'd0;
         idx_q     <= '0;
         wdata_q   <= 32'd0;
         wstrb_q   <= 4'd0;
         mem_rdata <= 32'd0;
`ifdef MEM_RESPONDER_OOR_EN
         err_q     <= 1'b0;
`endif
      end else begin
         if (rd_load) mem_rdata <= ram[rd_idx];
         if (state == ST_IDLE && mem_valid && hit) begin
            idx_q   <= off[AW+1:2];
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
            cnt     <= CNT_INIT;
            state   <= WAIT_CYCLES > 0 ? ST_WAIT : ST_RESP;
`ifdef MEM_RESPONDER_OOR_EN
            err_q   <= 1'b0;
         end else if (state == ST_IDLE && mem_valid) begin
            wstrb_q   <= 4'd0;
            err_q     <= 1'b1;
            mem_rdata <= 32'hDEAD_BEEF;
            state     <= ST_RESP;
`endif
         end else if (state == ST_WAIT) begin
            state <= !mem_valid ? ST_IDLE : cnt == 4'd0 ? ST_RESP : ST_WAIT;
            cnt   <= mem_valid && cnt != 4'd0 ? cnt - 4'd1 : cnt;
         end else if (state != ST_IDLE) begin
            state <= ST_IDLE;
         end
      end
   end
   // Commit latched byte lanes on the closing edge of the response cycle
   always_ff @(posedge clk) begin
      if (state == ST_RESP)
         for (int i = 0; i < 4; i++)
            if (wstrb_q[i]) ram[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
   end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder (WAIT_CYCLES=1 main instance, WAIT_CYCLES=3 latency instance)
module tb_mem_responder;
   localparam logic [31:0] BASE = 32'h0100_0000;
   logic        clk = 1'b0, rst = 1'b0;
   logic        mem_valid = 1'b0, mem_ready, mem_err;
   logic [31:0] mem_addr = 32'd0, mem_wdata = 32'd0, mem_rdata;
   logic [3:0]  mem_wstrb = 4'd0;
   logic        v3 = 1'b0, rdy3, err3;
   logic [31:0] a3 = 32'd0, d3 = 32'd0, rd3;
   logic [3:0]  s3 = 4'd0;
   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
      string       name;
   } exp_t;
   exp_t        sbq[$];
   exp_t        m;
   int          cyc = 0, errs = 0, checks = 0;
   logic [31:0] last_rd = 32'd0;

   mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut (
      .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_err(mem_err));

   mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_dut3 (
      .clk(clk), .rst(rst), .mem_valid(v3), .mem_ready(rdy3), .mem_addr(a3),
      .mem_wdata(d3), .mem_wstrb(s3), .mem_rdata(rd3), .mem_err(err3));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: every response must match the oldest expected entry
   always @(negedge clk) begin
      if (rst && mem_ready) begin
         if (sbq.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL unexpected_ready: got ready=1 at cycle %0d expected no response", cyc);
         end else begin
            m = sbq.pop_front();
            chk({m.name, "_rdata"}, mem_rdata, m.rdata);
            chk({m.name, "_err"}, {31'd0, mem_err}, {31'd0, m.err});
            chk({m.name, "_cycle"}, cyc, m.cyc);
         end
      end
   end

   // mode: 0 normal, 1 drop valid in WAIT, 2 change fields in WAIT, 3 reset in WAIT
   task automatic do_req(string nm, logic [31:0] a, logic [31:0] d, logic [3:0] s, logic [31:0] x, int mode);
      exp_t e;
      logic hit;
      int   n;
      @(negedge clk);
      mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
      hit = (a - BASE) < 32'd4096;
      e.name = nm;
      if (mode == 0 || mode == 2) begin
         if (hit) begin
            e.rdata = (s == 4'd0) ? x : last_rd;
            e.err = 1'b0;
            e.cyc = cyc + 2;
            if (s == 4'd0) last_rd = x;
            sbq.push_back(e);
         end
`ifdef MEM_RESPONDER_OOR_EN
         else begin
            e.rdata = 32'hDEAD_BEEF;
            e.err = 1'b1;
            e.cyc = cyc + 1;
            last_rd = 32'hDEAD_BEEF;
            sbq.push_back(e);
         end
`endif
      end
      if (mode == 1) begin
         @(negedge clk);
         mem_valid = 1'b0;
         repeat (5) @(negedge clk);
      end else if (mode == 3) begin
         @(negedge clk);
         rst = 1'b0;
         #1;
         chk({nm, "_rst_ready"}, {31'd0, mem_ready}, 32'd0);
         chk({nm, "_rst_rdata"}, mem_rdata, 32'd0);
         chk({nm, "_rst_err"}, {31'd0, mem_err}, 32'd0);
         mem_valid = 1'b0;
         last_rd = 32'd0;
         @(negedge clk);
         rst = 1'b1;
      end else if (mode == 0 && !hit) begin
`ifdef MEM_RESPONDER_OOR_EN
         n = 0;
         while (!mem_ready && n < 20) begin @(negedge clk); n++; end
         if (!mem_ready) begin checks++; errs++; $display("FAIL %s_timeout: got no ready expected ready", nm); end
`else
         repeat (20) @(negedge clk);
`endif
      end else begin
         if (mode == 2) begin
            @(negedge clk);
            mem_addr = a + 32'd4; mem_wdata = ~d; mem_wstrb = 4'hF;
         end
         n = 0;
         while (!mem_ready && n < 20) begin @(negedge clk); n++; end
         if (!mem_ready) begin checks++; errs++; $display("FAIL %s_timeout: got no ready expected ready", nm); end
      end
      mem_valid = 1'b0; mem_wstrb = 4'd0;
   endtask

   task automatic req3(string nm, logic [31:0] a, logic [31:0] d, logic [3:0] s, logic [31:0] x);
      int n;
      @(negedge clk);
      v3 = 1'b1; a3 = a; d3 = d; s3 = s; n = 0;
      do begin @(negedge clk); n++; end while (!rdy3 && n < 30);
      chk({nm, "_latency"}, n, 4);
      if (s == 4'd0) chk({nm, "_rdata"}, rd3, x);
      v3 = 1'b0;
      @(negedge clk);
      chk({nm, "_one_cycle"}, {31'd0, rdy3}, 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_ready", {31'd0, mem_ready}, 32'd0);
      chk("reset_rdata", mem_rdata, 32'd0);
      chk("reset_err", {31'd0, mem_err}, 32'd0);
      chk("reset3_rdata", rd3, 32'd0);
      rst = 1'b1;
      do_req("wr_word",  32'h0100_0010, 32'h1234_5678, 4'hF, 32'd0, 0);
      do_req("rd_word",  32'h0100_0010, 32'd0, 4'h0, 32'h1234_5678, 0);
      do_req("wr_base8", 32'h0100_0008, 32'h1122_3344, 4'hF, 32'd0, 0);
      do_req("wr_lane2", 32'h0100_0008, 32'h00AB_0000, 4'h4, 32'd0, 0);
      do_req("rd_lane2", 32'h0100_0008, 32'd0, 4'h0, 32'h11AB_3344, 0);
      do_req("wr_mixed", 32'h0100_0010, 32'hAABB_CCDD, 4'h6, 32'd0, 0);
      do_req("rd_mixed", 32'h0100_0010, 32'd0, 4'h0, 32'h12BB_CC78, 0);
      do_req("wr_first", 32'h0100_0000, 32'hA5A5_A5A5, 4'hF, 32'd0, 0);
      do_req("wr_last",  32'h0100_0FFC, 32'hCAFE_F00D, 4'hF, 32'd0, 0);
      do_req("rd_first", 32'h0100_0000, 32'd0, 4'h0, 32'hA5A5_A5A5, 0);
      do_req("rd_last",  32'h0100_0FFC, 32'd0, 4'h0, 32'hCAFE_F00D, 0);
      do_req("wr_abort", 32'h0100_0010, 32'h0000_0000, 4'hF, 32'd0, 1);
      do_req("rd_abort", 32'h0100_0010, 32'd0, 4'h0, 32'h12BB_CC78, 0);
      do_req("wr_hold",  32'h0100_0020, 32'h55AA_55AA, 4'hF, 32'd0, 2);
      do_req("rd_hold",  32'h0100_0020, 32'd0, 4'h0, 32'h55AA_55AA, 0);
      do_req("rd_below", 32'h00FF_FFFC, 32'd0, 4'h0, 32'd0, 0);
      do_req("rd_above", 32'h0100_1000, 32'd0, 4'h0, 32'd0, 0);
      do_req("rd_after_oor", 32'h0100_0008, 32'd0, 4'h0, 32'h11AB_3344, 0);
      do_req("wr_rst",   32'h0100_0000, 32'h0000_0000, 4'hF, 32'd0, 3);
      do_req("rd_rst",   32'h0100_0000, 32'd0, 4'h0, 32'hA5A5_A5A5, 0);
      do_req("b2b_a",    32'h0100_0FFC, 32'd0, 4'h0, 32'hCAFE_F00D, 0);
      do_req("b2b_b",    32'h0100_0020, 32'd0, 4'h0, 32'h55AA_55AA, 0);
      req3("w3_write", 32'h0100_0004, 32'h0BAD_CAFE, 4'hF, 32'd0);
      req3("w3_read",  32'h0100_0004, 32'd0, 4'h0, 32'h0BAD_CAFE);
      repeat (5) @(negedge clk);
      chk("sb_empty", sbq.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish");
      $fatal(1, "timeout");
   end
endmodule
